mc_ctrl_fsm: RTL and testbench

//  Multi-cycle MIPS control unit. Sequences the shared datapath (single ALU, unified

---
 rtl/mc_ctrl_fsm_pkg.sv | 151 +++++++++++++++
 rtl/mc_op_decode.sv | 27 ++
 rtl/mc_ctrl_fsm.sv | 125 ++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: state encodings,
// opcode constants, selector codes common with the datapath muxes.
package mc_ctrl_fsm_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_RWB    = 4'd8,
        S_IEXEC  = 4'd9,
        S_IWB    = 4'd10,
        S_BRANCH = 4'd11,
        S_JUMP   = 4'd12,
        S_JAL    = 4'd13
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [1:0] PCSRC_ALU  = 2'b00;
    localparam logic [1:0] PCSRC_OUT  = 2'b01;
    localparam logic [1:0] PCSRC_JMP  = 2'b10;
    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;
    localparam logic [1:0] ALU_OR     = 2'b11;
    localparam logic [1:0] RDST_RT    = 2'b00;
    localparam logic [1:0] RDST_RD    = 2'b01;
    localparam logic [1:0] RDST_RA    = 2'b10;
    localparam logic [1:0] WB_ALU     = 2'b00;
    localparam logic [1:0] WB_MDR     = 2'b01;
    localparam logic [1:0] WB_PC      = 2'b10;

    typedef struct packed {
        logic lw;
        logic sw;
        logic rtype;
        logic beq;
        logic addi;
        logic ori;
        logic j;
        logic jal;
    } op_cls_t;

    // fetch/pc_write/branch are qualifiers: the real enables are
    // combined with mem_ready / alu_zero in the top.
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       fetch;
        logic       pc_write;
        logic       branch;
        logic [1:0] pcsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       ext_sel;
        logic       imm_shift;
        logic [1:0] alu_op;
        logic [1:0] regdst;
        logic [1:0] memtoreg;
        logic       reg_we;
    } ctrl_t;

    function automatic ctrl_t moore_ctrl(input state_t s,
                                         input logic   is_addi);
        ctrl_t c;
        c = '0;
        unique case (s)
            S_FETCH: begin
                c.mem_req = 1'b1;
                c.fetch   = 1'b1;
                c.alusrcb = SRCB_FOUR;
            end
            S_DECODE: begin
                c.alusrcb   = SRCB_IMM;
                c.ext_sel   = 1'b1;
                c.imm_shift = 1'b1;
            end
            S_MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_IMM;
                c.ext_sel = 1'b1;
            end
            S_MEMRD: begin
                c.mem_req = 1'b1;
                c.iord    = 1'b1;
            end
            S_MEMWB: begin
                c.reg_we   = 1'b1;
                c.memtoreg = WB_MDR;
            end
            S_MEMWR: begin
                c.mem_req = 1'b1;
                c.mem_we  = 1'b1;
                c.iord    = 1'b1;
            end
            S_EXEC: begin
                c.alusrca = 1'b1;
                c.alu_op  = ALU_FUNCT;
            end
            S_RWB: begin
                c.reg_we = 1'b1;
                c.regdst = RDST_RD;
            end
            S_IEXEC: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_IMM;
                c.ext_sel = is_addi;
                c.alu_op  = is_addi ? ALU_ADD : ALU_OR;
            end
            S_IWB: begin
                c.reg_we = 1'b1;
            end
            S_BRANCH: begin
                c.alusrca = 1'b1;
                c.alu_op  = ALU_SUB;
                c.pcsrc   = PCSRC_OUT;
                c.branch  = 1'b1;
            end
            S_JUMP: begin
                c.pcsrc    = PCSRC_JMP;
                c.pc_write = 1'b1;
            end
            S_JAL: begin
                c.pcsrc    = PCSRC_JMP;
                c.pc_write = 1'b1;
                c.reg_we   = 1'b1;
                c.regdst   = RDST_RA;
                c.memtoreg = WB_PC;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_op_decode.sv
// Opcode classifier: one-hot instruction class plus illegal flag.
// Ports: i_opcode (IR[31:26]) -> o_cls (one-hot), o_illegal.
module mc_op_decode
    import mc_ctrl_fsm_pkg::*;
(
    input  logic [5:0] i_opcode,
    output op_cls_t    o_cls,
    output logic       o_illegal
);

    always_comb begin
        o_cls     = '0;
        o_illegal = 1'b0;
        unique case (i_opcode)
            OP_LW:   o_cls.lw    = 1'b1;
            OP_SW:   o_cls.sw    = 1'b1;
            OP_R:    o_cls.rtype = 1'b1;
            OP_BEQ:  o_cls.beq   = 1'b1;
            OP_ADDI: o_cls.addi  = 1'b1;
            OP_ORI:  o_cls.ori   = 1'b1;
            OP_J:    o_cls.j     = 1'b1;
            OP_JAL:  o_cls.jal   = 1'b1;
            default: o_illegal   = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM: sequences the shared datapath selectors,
// enables and memory requests; counts retired instructions.
// Ports: clk, rst_n, opcode, funct, alu_zero, mem_ready in; datapath
// controls, illegal_op pulse, instr_cnt and debug state out.
module mc_ctrl_fsm
    import mc_ctrl_fsm_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pcsrc,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic             ext_sel,
    output logic             imm_shift,
    output logic [1:0]       alu_op,
    output logic [1:0]       regdst,
    output logic [1:0]       memtoreg,
    output logic             reg_we,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [3:0]       state
);

    state_t            r_state;
    state_t            w_nxt;
    ctrl_t             r_ctrl;
    logic [CNT_W-1:0]  r_cnt;
    op_cls_t           w_cls;
    logic              w_ill;
    logic              w_retire;
    logic              w_unused_funct;

    // funct is consumed by the ALU control, not by sequencing
    assign w_unused_funct = ^funct;

    mc_op_decode u_dec (
        .i_opcode  (opcode),
        .o_cls     (w_cls),
        .o_illegal (w_ill)
    );

    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            S_IDLE:   w_nxt = S_FETCH;
            S_FETCH:  if (mem_ready) w_nxt = S_DECODE;
            S_DECODE: begin
                unique case (1'b1)
                    w_cls.lw,
                    w_cls.sw:    w_nxt = S_MEMADR;
                    w_cls.rtype: w_nxt = S_EXEC;
                    w_cls.beq:   w_nxt = S_BRANCH;
                    w_cls.addi,
                    w_cls.ori:   w_nxt = S_IEXEC;
                    w_cls.j:     w_nxt = S_JUMP;
                    w_cls.jal:   w_nxt = S_JAL;
                    default:     w_nxt = S_FETCH;
                endcase
            end
            S_MEMADR: w_nxt = w_cls.sw ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) w_nxt = S_MEMWB;
            S_MEMWB:  w_nxt = S_FETCH;
            S_MEMWR:  if (mem_ready) w_nxt = S_FETCH;
            S_EXEC:   w_nxt = S_RWB;
            S_RWB:    w_nxt = S_FETCH;
            S_IEXEC:  w_nxt = S_IWB;
            S_IWB:    w_nxt = S_FETCH;
            S_BRANCH: w_nxt = S_FETCH;
            S_JUMP:   w_nxt = S_FETCH;
            S_JAL:    w_nxt = S_FETCH;
            default:  w_nxt = S_IDLE;
        endcase
    end

    // Entering FETCH from a work state retires; IDLE start,
    // fetch stalls and illegal-op aborts do not.
    assign w_retire = (w_nxt == S_FETCH) &&
        !(r_state inside {S_IDLE, S_FETCH, S_DECODE});

    // Controls are registered from the next state so they
    // line up with r_state without a decode after the flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ctrl  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nxt;
            r_ctrl  <= moore_ctrl(w_nxt, w_cls.addi);
            if (w_retire) r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign mem_req    = r_ctrl.mem_req;
    assign mem_we     = r_ctrl.mem_we;
    assign iord       = r_ctrl.iord;
    assign ir_we      = r_ctrl.fetch & mem_ready;
    assign pc_we      = r_ctrl.pc_write
                      | (r_ctrl.branch & alu_zero)
                      | (r_ctrl.fetch & mem_ready);
    assign pcsrc      = r_ctrl.pcsrc;
    assign alusrca    = r_ctrl.alusrca;
    assign alusrcb    = r_ctrl.alusrcb;
    assign ext_sel    = r_ctrl.ext_sel;
    assign imm_shift  = r_ctrl.imm_shift;
    assign alu_op     = r_ctrl.alu_op;
    assign regdst     = r_ctrl.regdst;
    assign memtoreg   = r_ctrl.memtoreg;
    assign reg_we     = r_ctrl.reg_we;
    assign illegal_op = (r_state == S_DECODE) & w_ill;
    assign instr_cnt  = r_cnt;
    assign state      = r_state;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: per-cycle expected control words queued per
// instruction and compared at the falling edge.
module tb_mc_ctrl_fsm;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] ORI  = 6'b001101;
    localparam logic [5:0] J    = 6'b000010;
    localparam logic [5:0] JAL  = 6'b000011;
    localparam logic [5:0] BAD  = 6'b111111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        alu_zero;
    logic        mem_ready;
    logic        mem_req, mem_we, iord, ir_we, pc_we;
    logic [1:0]  pcsrc, alusrcb, alu_op, regdst, memtoreg;
    logic        alusrca, ext_sel, imm_shift, reg_we, illegal_op;
    logic [31:0] instr_cnt;
    logic [3:0]  state;

    always #5 clk = ~clk;

    mc_ctrl_fsm #(.CNT_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct      (funct),
        .alu_zero   (alu_zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .pcsrc      (pcsrc),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .ext_sel    (ext_sel),
        .imm_shift  (imm_shift),
        .alu_op     (alu_op),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .reg_we     (reg_we),
        .illegal_op (illegal_op),
        .instr_cnt  (instr_cnt),
        .state      (state)
    );

    typedef struct packed {
        logic [3:0]  st;
        logic        mem_req;
        logic        mem_we;
        logic        iord;
        logic        ir_we;
        logic        pc_we;
        logic [1:0]  pcsrc;
        logic        alusrca;
        logic [1:0]  alusrcb;
        logic        ext_sel;
        logic        imm_shift;
        logic [1:0]  alu_op;
        logic [1:0]  regdst;
        logic [1:0]  memtoreg;
        logic        reg_we;
        logic        illegal_op;
        logic [31:0] cnt;
    } obs_t;

    typedef struct {
        logic [5:0] op;
        logic       z;
        logic       rdy;
        obs_t       e;
        string      nm;
    } rec_t;

    typedef struct {
        logic [5:0] op;
        logic       z;
        int         fs;
        int         ms;
        string      nm;
    } vec_t;

    rec_t        q[$];
    vec_t        vt[12];
    int          total = 0;
    int          bad = 0;
    logic [31:0] m_cnt = 0;

    function automatic obs_t get_obs();
        obs_t a;
        a.st         = state;
        a.mem_req    = mem_req;
        a.mem_we     = mem_we;
        a.iord       = iord;
        a.ir_we      = ir_we;
        a.pc_we      = pc_we;
        a.pcsrc      = pcsrc;
        a.alusrca    = alusrca;
        a.alusrcb    = alusrcb;
        a.ext_sel    = ext_sel;
        a.imm_shift  = imm_shift;
        a.alu_op     = alu_op;
        a.regdst     = regdst;
        a.memtoreg   = memtoreg;
        a.reg_we     = reg_we;
        a.illegal_op = illegal_op;
        a.cnt        = instr_cnt;
        return a;
    endfunction

    function automatic obs_t blank(input logic [3:0] st);
        obs_t e;
        e     = '0;
        e.st  = st;
        e.cnt = m_cnt;
        return e;
    endfunction

    task automatic check(input obs_t e, input string nm);
        obs_t a;
        a = get_obs();
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got st=%0d word=%h want st=%0d word=%h",
                     nm, a.st, a, e.st, e);
        end
    endtask

    task automatic add(input logic [5:0] op, input logic z,
                       input logic rdy, input obs_t e,
                       input string nm);
        rec_t r;
        r.op  = op;
        r.z   = z;
        r.rdy = rdy;
        r.e   = e;
        r.nm  = nm;
        q.push_back(r);
    endtask

    // Expected per-cycle words for one instruction, straight from
    // the state table; fs/ms = fetch/memory wait cycles.
    task automatic push_instr(input logic [5:0] op, input logic z,
                              input int fs, input int ms,
                              input string nm);
        obs_t e;
        logic [3:0] mst;
        for (int i = 0; i < fs; i++) begin
            e = blank(4'd1);
            e.mem_req = 1'b1;
            e.alusrcb = 2'b01;
            add(op, z, 1'b0, e, {nm, "_fstall"});
        end
        e = blank(4'd1);
        e.mem_req = 1'b1;
        e.alusrcb = 2'b01;
        e.ir_we   = 1'b1;
        e.pc_we   = 1'b1;
        add(op, z, 1'b1, e, {nm, "_fetch"});
        e = blank(4'd2);
        e.alusrcb   = 2'b10;
        e.ext_sel   = 1'b1;
        e.imm_shift = 1'b1;
        if (!(op inside {LW, SW, RT, BEQ, ADDI, ORI, J, JAL})) begin
            e.illegal_op = 1'b1;
            add(op, z, 1'b1, e, {nm, "_decode"});
            return;
        end
        add(op, z, 1'b1, e, {nm, "_decode"});
        case (op)
            LW, SW: begin
                e = blank(4'd3);
                e.alusrca = 1'b1;
                e.alusrcb = 2'b10;
                e.ext_sel = 1'b1;
                add(op, z, 1'b1, e, {nm, "_memadr"});
                mst = (op == LW) ? 4'd4 : 4'd6;
                e = blank(mst);
                e.mem_req = 1'b1;
                e.iord    = 1'b1;
                e.mem_we  = (op == SW);
                for (int i = 0; i < ms; i++)
                    add(op, z, 1'b0, e, {nm, "_mstall"});
                add(op, z, 1'b1, e, {nm, "_mem"});
                if (op == LW) begin
                    e = blank(4'd5);
                    e.reg_we   = 1'b1;
                    e.memtoreg = 2'b01;
                    add(op, z, 1'b1, e, {nm, "_memwb"});
                end
            end
            RT: begin
                e = blank(4'd7);
                e.alusrca = 1'b1;
                e.alu_op  = 2'b10;
                add(op, z, 1'b1, e, {nm, "_exec"});
                e = blank(4'd8);
                e.reg_we = 1'b1;
                e.regdst = 2'b01;
                add(op, z, 1'b1, e, {nm, "_rwb"});
            end
            ADDI, ORI: begin
                e = blank(4'd9);
                e.alusrca = 1'b1;
                e.alusrcb = 2'b10;
                e.ext_sel = (op == ADDI);
                e.alu_op  = (op == ADDI) ? 2'b00 : 2'b11;
                add(op, z, 1'b1, e, {nm, "_iexec"});
                e = blank(4'd10);
                e.reg_we = 1'b1;
                add(op, z, 1'b1, e, {nm, "_iwb"});
            end
            BEQ: begin
                e = blank(4'd11);
                e.alusrca = 1'b1;
                e.alu_op  = 2'b01;
                e.pcsrc   = 2'b01;
                e.pc_we   = z;
                add(op, z, 1'b1, e, {nm, "_branch"});
            end
            J: begin
                e = blank(4'd12);
                e.pcsrc = 2'b10;
                e.pc_we = 1'b1;
                add(op, z, 1'b1, e, {nm, "_jump"});
            end
            default: begin
                e = blank(4'd13);
                e.pcsrc    = 2'b10;
                e.pc_we    = 1'b1;
                e.reg_we   = 1'b1;
                e.regdst   = 2'b10;
                e.memtoreg = 2'b10;
                add(op, z, 1'b1, e, {nm, "_jal"});
            end
        endcase
        m_cnt++;
    endtask

    task automatic drain_n(input int n);
        rec_t r;
        for (int i = 0; i < n && q.size() > 0; i++) begin
            r = q.pop_front();
            @(posedge clk);
            #1;
            opcode    = r.op;
            alu_zero  = r.z;
            mem_ready = r.rdy;
            funct     = 6'($urandom);
            @(negedge clk);
            check(r.e, r.nm);
        end
    endtask

    task automatic drain();
        drain_n(q.size());
    endtask

    initial begin
        vt[0]  = '{LW,   1'b0, 0, 0, "lw"};
        vt[1]  = '{SW,   1'b1, 0, 0, "sw"};
        vt[2]  = '{RT,   1'b1, 0, 0, "rtype"};
        vt[3]  = '{ADDI, 1'b0, 0, 0, "addi"};
        vt[4]  = '{ORI,  1'b1, 0, 0, "ori"};
        vt[5]  = '{BEQ,  1'b1, 0, 0, "beq_taken"};
        vt[6]  = '{BEQ,  1'b0, 0, 0, "beq_not"};
        vt[7]  = '{J,    1'b1, 0, 0, "j"};
        vt[8]  = '{JAL,  1'b1, 0, 0, "jal"};
        vt[9]  = '{BAD,  1'b1, 0, 0, "illegal"};
        vt[10] = '{LW,   1'b1, 2, 2, "lw_stall"};
        vt[11] = '{ORI,  1'b0, 1, 0, "ori_fstall"};

        rst_n     = 1'b0;
        opcode    = 6'd0;
        funct     = 6'd0;
        alu_zero  = 1'b1;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check(blank(4'd0), "reset_hold");
        rst_n = 1'b1;
        #1;
        check(blank(4'd0), "reset_release_idle");

        for (int i = 0; i < 12; i++) begin
            push_instr(vt[i].op, vt[i].z, vt[i].fs, vt[i].ms,
                       vt[i].nm);
            drain();
        end

        push_instr(SW, 1'b0, 0, 3, "sw_wait3");
        drain();
        push_instr(JAL, 1'b0, 0, 0, "jal2");
        drain();

        // abandon a load two cycles into its memory wait
        push_instr(LW, 1'b0, 0, 5, "lw_rst");
        drain_n(5);
        q.delete();
        #1;
        rst_n = 1'b0;
        m_cnt = 0;
        #1;
        check(blank(4'd0), "rst_async_memrd");
        @(posedge clk);
        #1;
        mem_ready = 1'b1;
        check(blank(4'd0), "rst_held");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check(blank(4'd0), "rst_release2");
        push_instr(JAL, 1'b1, 0, 0, "jal_after_rst");
        push_instr(RT, 1'b0, 0, 0, "r_after_rst");
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
